// File: rtl/press_target_counter_pkg.sv
// +--------------------------------------------------------------------+
// | led_ctrl_pkg : shared state type and default sizing for press path |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package led_ctrl_pkg;

  typedef enum logic {
    CNT_COUNT = 1'b0,
    CNT_HOLD  = 1'b1
  } press_state_t;

  // 20 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 1_000_000;
  // 2^25 cycles spans two periods of the clk/2^24 animation clock
  localparam int HOLD_DEFAULT     = 33_554_432;
  localparam int TARGET_DEFAULT   = 10;
  localparam int CNT_W_DEFAULT    = 4;

endpackage

`default_nettype wire

// File: rtl/press_target_counter_debounce.sv
// +--------------------------------------------------------------------+
// | btn_debounce : 2-flop sync, stability counter, registered press    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press_pulse
);

  localparam int              c_db_w    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

  logic              sync1_q;
  logic              sync2_q;
  logic              level_q;
  logic              level_d;
  logic              level_prev_q;
  logic              pulse_q;
  logic [c_db_w-1:0] db_cnt_q;
  logic [c_db_w-1:0] db_cnt_d;

  // Any sample equal to the accepted level restarts the stability window.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sync2_q != level_q) begin
      if (db_cnt_q == c_db_last) begin
        level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_in;
      sync2_q      <= sync1_q;
      db_cnt_q     <= db_cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      pulse_q      <= level_q & ~level_prev_q;
    end
  end

  assign level       = level_q;
  assign press_pulse = pulse_q;

endmodule

`default_nettype wire

// File: rtl/press_target_counter.sv
// +--------------------------------------------------------------------+
// | press_target_counter : counts debounced presses, holds a trigger   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module press_target_counter
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int TARGET          = TARGET_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_in,
  input  logic             clear,
  output logic             press_pulse,
  output logic [CNT_W-1:0] count,
  output logic             count_reached
);

  localparam int                  c_hold_w    = $clog2(HOLD_CYCLES) + 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]    c_target    = CNT_W'(TARGET);

  if (CNT_W < 1 || CNT_W > 30) begin : g_bad_cnt_w
    $error("press_target_counter: CNT_W must be in 1..30");
  end

  if (TARGET < 1 || TARGET >= (1 << CNT_W)) begin : g_bad_target
    $error("press_target_counter: TARGET must satisfy 1 <= TARGET < 2**CNT_W");
  end

  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_cycles
    $error("press_target_counter: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
  end

  logic w_press;
  logic w_unused_level;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .level      (w_unused_level),
    .press_pulse(w_press)
  );

  press_state_t        state_q;
  logic [CNT_W-1:0]    count_q;
  logic                reached_q;
  logic [c_hold_w-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= CNT_COUNT;
      count_q   <= '0;
      reached_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        CNT_COUNT: begin
          // clear outranks a simultaneous press
          if (clear) begin
            count_q <= '0;
          end else if (w_press) begin
            if (count_q + 1'b1 == c_target) begin
              count_q   <= c_target;
              reached_q <= 1'b1;
              hold_q    <= '0;
              state_q   <= CNT_HOLD;
            end else begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        CNT_HOLD: begin
          // presses are ignored here; count stays frozen at TARGET
          if (clear || hold_q == c_hold_last) begin
            reached_q <= 1'b0;
            count_q   <= '0;
            hold_q    <= '0;
            state_q   <= CNT_COUNT;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign press_pulse   = w_press;
  assign count         = count_q;
  assign count_reached = reached_q;

endmodule

`default_nettype wire

// File: tb/tb_press_target_counter.sv
// +--------------------------------------------------------------------+
// | tb_press_target_counter : scoreboarded directed bench              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_press_target_counter;

  localparam int D = 4;
  localparam int T = 3;
  localparam int W = 4;
  localparam int H = 16;

  logic         clk    = 1'b0;
  logic         reset  = 1'b0;
  logic         btn_in = 1'b0;
  logic         clear  = 1'b0;
  logic         press_pulse;
  logic [W-1:0] count;
  logic         count_reached;

  press_target_counter #(
    .DEBOUNCE_CYCLES(D),
    .TARGET         (T),
    .CNT_W          (W),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_in       (btn_in),
    .clear        (clear),
    .press_pulse  (press_pulse),
    .count        (count),
    .count_reached(count_reached)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [W-1:0] cnt;
    logic         rch;
  } chg_t;

  chg_t chg_q[$];
  int   pulse_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void check(input string name, input bit ok, input string detail);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endfunction

  function automatic void push_chg(input int c, input logic [W-1:0] cnt, input logic rch);
    chg_t e;
    e.cyc = c;
    e.cnt = cnt;
    e.rch = rch;
    chg_q.push_back(e);
  endfunction

  // Monitor: pops expectations whenever the DUT pulses or changes count/trigger.
  initial begin : mon
    logic [W-1:0] pc;
    logic         pr;
    chg_t         e;
    int           pe;
    pc = '0;
    pr = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (press_pulse === 1'b1) begin
        if (pulse_q.size() == 0) begin
          check("pulse_unexpected", 1'b0, $sformatf("press_pulse=1 at cycle %0d, required 0", cyc));
        end else begin
          pe = pulse_q.pop_front();
          check("pulse_time", pe == cyc, $sformatf("press_pulse at cycle %0d, required cycle %0d", cyc, pe));
        end
      end
      while (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
        pe = pulse_q.pop_front();
        check("pulse_missing", 1'b0, $sformatf("no press_pulse by cycle %0d, required at cycle %0d", cyc, pe));
      end
      if (count !== pc || count_reached !== pr) begin
        if (chg_q.size() == 0) begin
          check("change_unexpected", 1'b0, $sformatf("count=%0d reached=%0b at cycle %0d, required count=%0d reached=%0b",
                                                     count, count_reached, cyc, pc, pr));
        end else begin
          e = chg_q.pop_front();
          check("change", e.cyc == cyc && e.cnt === count && e.rch === count_reached,
                $sformatf("cycle %0d count=%0d reached=%0b, required cycle %0d count=%0d reached=%0b",
                          cyc, count, count_reached, e.cyc, e.cnt, e.rch));
        end
        pc = count;
        pr = count_reached;
      end
      while (chg_q.size() > 0 && chg_q[0].cyc < cyc) begin
        e = chg_q.pop_front();
        check("change_missing", 1'b0, $sformatf("count=%0d reached=%0b at cycle %0d, required count=%0d reached=%0b at cycle %0d",
                                                count, count_reached, cyc, e.cnt, e.rch, e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc + 1 < c) @(negedge clk);
  endtask

  // Button first sampled high at posedge q; pulse seen at q+D+2, count at q+D+3.
  task automatic press(input int hi, input int lo, input bit chg, input logic [W-1:0] ec,
                       input logic er, output int q);
    q = cyc + 1;
    btn_in = 1'b1;
    pulse_q.push_back(q + D + 2);
    if (chg) push_chg(q + D + 3, ec, er);
    tick(hi);
    btn_in = 1'b0;
    tick(lo);
  endtask

  initial begin : stim
    int q;
    int e;
    int r;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_pulse", press_pulse === 1'b0, $sformatf("press_pulse=%0b, required 0", press_pulse));
      check("reset_count", count === '0, $sformatf("count=%0d, required 0", count));
      check("reset_reached", count_reached === 1'b0, $sformatf("count_reached=%0b, required 0", count_reached));
      btn_in = ~btn_in;
    end
    reset  = 1'b1;
    btn_in = 1'b0;
    tick(3);

    press(10, 10, 1'b1, 4'd1, 1'b0, q);

    // glitches shorter than D cycles
    btn_in = 1'b1; tick(3);
    btn_in = 1'b0; tick(5);
    btn_in = 1'b1; tick(2);
    btn_in = 1'b0; tick(10);
    check("glitch_count", count === 4'd1, $sformatf("count=%0d, required 1", count));

    clear = 1'b1;
    push_chg(cyc + 1, 4'd0, 1'b0);
    tick(1);
    clear = 1'b0;
    tick(3);

    // full trigger and natural hold expiry
    press(10, 10, 1'b1, 4'd1, 1'b0, q);
    press(10, 10, 1'b1, 4'd2, 1'b0, q);
    press(10, 10, 1'b1, 4'd3, 1'b1, q);
    push_chg(q + D + 3 + H, 4'd0, 1'b0);
    check("hold_level", count_reached === 1'b1 && count === 4'd3,
          $sformatf("count=%0d reached=%0b mid-hold, required count=3 reached=1", count, count_reached));
    wait_until(q + D + 3 + H + 3);

    // presses during hold are ignored, the last one on the final hold edge
    press(4, 4, 1'b1, 4'd1, 1'b0, q);
    press(4, 4, 1'b1, 4'd2, 1'b0, q);
    press(4, 4, 1'b1, 4'd3, 1'b1, q);
    push_chg(q + D + 3 + H, 4'd0, 1'b0);
    press(4, 4, 1'b0, 4'd0, 1'b0, e);
    press(4, 4, 1'b0, 4'd0, 1'b0, e);
    tick(10);

    // clear aborts the hold at hold cycle 5
    press(4, 4, 1'b1, 4'd1, 1'b0, q);
    press(4, 4, 1'b1, 4'd2, 1'b0, q);
    press(4, 0, 1'b1, 4'd3, 1'b1, q);
    e = q + D + 3;
    wait_until(e + 5);
    clear = 1'b1;
    push_chg(e + 5, 4'd0, 1'b0);
    tick(1);
    clear = 1'b0;
    tick(16);

    // clear coincident with the press that would have triggered
    press(10, 10, 1'b1, 4'd1, 1'b0, q);
    press(10, 10, 1'b1, 4'd2, 1'b0, q);
    q = cyc + 1;
    btn_in = 1'b1;
    pulse_q.push_back(q + D + 2);
    wait_until(q + D + 3);
    clear = 1'b1;
    push_chg(q + D + 3, 4'd0, 1'b0);
    tick(1);
    clear = 1'b0;
    wait_until(q + 10);
    btn_in = 1'b0;
    tick(12);
    check("clear_wins", count === 4'd0 && count_reached === 1'b0,
          $sformatf("count=%0d reached=%0b, required count=0 reached=0", count, count_reached));

    // reset mid-hold with the button held through release
    press(4, 4, 1'b1, 4'd1, 1'b0, q);
    press(4, 4, 1'b1, 4'd2, 1'b0, q);
    press(4, 4, 1'b1, 4'd3, 1'b1, q);
    e = q + D + 3;
    btn_in = 1'b1;
    pulse_q.push_back(q + 8 + D + 2);
    wait_until(e + 10);
    reset = 1'b0;
    push_chg(e + 10, 4'd0, 1'b0);
    tick(1);
    check("reset_hold_reached", count_reached === 1'b0,
          $sformatf("count_reached=%0b after reset edge, required 0", count_reached));
    tick(1);
    reset = 1'b1;
    r = cyc + 1;
    pulse_q.push_back(r + D + 2);
    push_chg(r + D + 3, 4'd1, 1'b0);
    tick(12);
    btn_in = 1'b0;
    tick(12);

    check("pulse_queue_drained", pulse_q.size() == 0,
          $sformatf("%0d pulse expectations left, required 0", pulse_q.size()));
    check("change_queue_drained", chg_q.size() == 0,
          $sformatf("%0d change expectations left, required 0", chg_q.size()));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
